// File: rtl/register_file16.sv
// ---------------------------------------------------------------------------
// register_file16 : 16 x N register file, one write port, two async read ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module register_file16 #(
  parameter int unsigned N        = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [3:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [3:0]   rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [3:0]   rd_addr1,
  output logic [N-1:0] rd_data1,
  output logic [7:0]   wr_count
);

  localparam int NUM_REGS  = 16;
  localparam int NUM_PORTS = 2;

  logic [N-1:0]          regs_q [NUM_REGS];
  logic [N-1:0]          regs_d [NUM_REGS];
  logic [7:0]            wr_count_q;
  logic [7:0]            wr_count_d;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  commit;

  logic [3:0]            rd_addr [NUM_PORTS];
  logic [N-1:0]          rd_data [NUM_PORTS];

  // Gating on wr_ena first keeps an undriven wr_addr harmless when idle.
  always_comb begin
    wr_sel = '0;
    if (wr_ena) begin
      wr_sel[wr_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      wr_sel[0] = 1'b0;
    end
    commit = |wr_sel;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = wr_sel[i] ? wr_data : regs_q[i];
    end
    wr_count_d = wr_count_q;
    if (commit && (wr_count_q != 8'hFF)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count   = wr_count_q;
  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;
  assign rd_data0   = rd_data[0];
  assign rd_data1   = rd_data[1];

  // Per-port binary mux tree; address bit k steers tree level k+1.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_port
    logic [N-1:0] lvl1 [8];
    logic [N-1:0] lvl2 [4];
    logic [N-1:0] lvl3 [2];
    logic [N-1:0] tree_out;
    logic         zero_hit;
    logic         byp_hit;

    for (genvar i = 0; i < 8; i++) begin : g_lvl1
      assign lvl1[i] = rd_addr[p][0] ? regs_q[2*i+1] : regs_q[2*i];
    end
    for (genvar i = 0; i < 4; i++) begin : g_lvl2
      assign lvl2[i] = rd_addr[p][1] ? lvl1[2*i+1] : lvl1[2*i];
    end
    for (genvar i = 0; i < 2; i++) begin : g_lvl3
      assign lvl3[i] = rd_addr[p][2] ? lvl2[2*i+1] : lvl2[2*i];
    end
    assign tree_out = rd_addr[p][3] ? lvl3[1] : lvl3[0];

    assign zero_hit = (ZERO_REG != 0) && (rd_addr[p] == 4'd0);
    assign byp_hit  = (BYPASS != 0) && wr_ena && (rd_addr[p] == wr_addr);

    // Zero register outranks forwarding.
    assign rd_data[p] = zero_hit ? '0 :
                        byp_hit  ? wr_data : tree_out;
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file16.sv
// ---------------------------------------------------------------------------
// tb_register_file16 : randomized + directed checks of register_file16
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_register_file16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_ena;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr0;
  logic [3:0]  rd_addr1;
  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;
  logic [7:0]  wc_a, wc_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: A has a hardwired r0 and forwarding, B has neither.
  logic [31:0] m_a [16];
  logic [31:0] m_b [16];
  int          cnt_a;
  int          cnt_b;

  always #5 clk = ~clk;

  register_file16 dut_a (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd0_a), .rd_addr1(rd_addr1), .rd_data1(rd1_a),
    .wr_count(wc_a)
  );

  register_file16 #(.N(32), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd0_b), .rd_addr1(rd_addr1), .rd_data1(rd1_b),
    .wr_count(wc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_a(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
    if (wr_ena && (a == wr_addr)) return wr_data;
    return m_a[a];
  endfunction

  function automatic logic [31:0] exp_b(input logic [3:0] a);
    return m_b[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic model_edge();
    if (wr_ena && (wr_addr != 4'd0)) begin
      m_a[wr_addr] = wr_data;
      if (cnt_a < 255) cnt_a++;
    end
    if (wr_ena) begin
      m_b[wr_addr] = wr_data;
      if (cnt_b < 255) cnt_b++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/a_rd0"}, rd0_a, exp_a(rd_addr0));
    check({tag, "/a_rd1"}, rd1_a, exp_a(rd_addr1));
    check({tag, "/b_rd0"}, rd0_b, exp_b(rd_addr0));
    check({tag, "/b_rd1"}, rd1_b, exp_b(rd_addr1));
    check({tag, "/a_cnt"}, {24'h0, wc_a}, 32'(cnt_a));
    check({tag, "/b_cnt"}, {24'h0, wc_b}, 32'(cnt_b));
  endtask

  // Drive one cycle's inputs, check combinational reads, then take the edge.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] a0, input logic [3:0] a1, input string tag);
    wr_ena   = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr0 = a0;
    rd_addr1 = a1;
    #2;
    check_all(tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'd0, 32'h0, 4'(k), 4'(15 - k), tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = 4'd5; rd_addr1 = 4'd0;
    model_clear();
    #3;
    check_all("reset_init");
    // Write presented during reset: forwarded on A, never stored.
    drive(1'b1, 4'd5, 32'h1234_5678, 4'd5, 4'd5, "reset_wr");
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 4'd5, 4'd0, "post_reset");

    // Mid-cycle async reset wipes a just-written register before any edge.
    drive(1'b1, 4'd5, 32'hDEAD_BEEF, 4'd0, 4'd1, "wr_r5");
    drive(1'b0, 4'd0, 32'h0, 4'd5, 4'd5, "rd_r5");
    rst = 1'b1;
    model_clear();
    #1;
    check("async_rst_a", rd0_a, 32'h0);
    check("async_rst_b", rd0_b, 32'h0);
    check("async_rst_cnt", {24'h0, wc_a}, 32'h0);
    #3;
    rst = 1'b0;
    #1;

    for (int k = 1; k < 16; k++) begin
      drive(1'b1, 4'(k), 32'h1000_0000 + 32'(k), 4'(k), 4'd0, "wr_all");
    end
    sweep("rd_all");
    check("cnt15", {24'h0, wc_a}, 32'd15);

    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 4'd0, 4'd0, "wr_zero");
    drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, "rd_zero");
    check("zero_cnt_a", {24'h0, wc_a}, 32'd15);
    check("zero_r0_b", rd0_b, 32'hFFFF_FFFF);

    drive(1'b1, 4'd7, 32'h1, 4'd7, 4'd7, "byp_pre");
    drive(1'b1, 4'd7, 32'hA5A5_A5A5, 4'd7, 4'd7, "bypass");
    drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd7, "byp_after");

    drive(1'b1, 4'd9, 32'h9999_0009, 4'd3, 4'd12, "dual_wr");
    drive(1'b0, 4'd0, 32'h0, 4'd9, 4'd12, "dual_rd");
    sweep("dual_sweep");

    // Reset asserted with a write in flight: the write is lost.
    rst = 1'b1;
    model_clear();
    drive(1'b1, 4'd4, 32'h4444_4444, 4'd4, 4'd0, "rst_inflight");
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 4'd4, 4'd4, "rst_lost");

    for (int i = 0; i < 300; i++) begin
      logic [3:0] wa;
      logic [3:0] a0;
      logic [3:0] a1;
      wa = 4'($urandom);
      a0 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      drive(1'($urandom_range(0, 1)), wa, $urandom, a0, a1, "rand");
    end
    sweep("rand_sweep");

    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'd1, $urandom, 4'd1, 4'd2, "sat");
    end
    drive(1'b0, 4'd0, 32'h0, 4'd1, 4'd1, "sat_rd");
    check("sat_cnt_a", {24'h0, wc_a}, 32'd255);
    check("sat_cnt_b", {24'h0, wc_b}, 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file16.md
REGISTER_FILE16 -- requirements
Module: register_file16

Interface
REQ-001 SHALL provide parameter N, default 32: width in bits of each register and of every data port.
REQ-002 SHALL provide parameter ZERO_REG, default 1: when 1, register 0 reads as constant zero and ignores writes.
REQ-003 SHALL provide parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL provide port wr_ena  input  1  write enable for the single write port.
REQ-007 SHALL provide port wr_addr  input  4  index of the register to write (0..15).
REQ-008 SHALL provide port wr_data  input  N  data to write.
REQ-009 SHALL provide port rd_addr0  input  4  index for read port 0.
REQ-010 SHALL provide port rd_data0  output  N  contents selected by rd_addr0.
REQ-011 SHALL provide port rd_addr1  input  4  index for read port 1.
REQ-012 SHALL provide port rd_data1  output  N  contents selected by rd_addr1.
REQ-013 SHALL provide port wr_count  output  8  saturating count of committed writes since reset.

Function
REQ-014 SHALL hold 16 registers r0..r15, each N bits.
REQ-015 SHALL decode wr_addr into a one-hot, 16-bit enable; only the addressed register may change on a clock edge.
REQ-016 SHALL load rk <= wr_data on the rising edge of clk when wr_ena=1 and wr_addr=k; all other registers hold their value.
REQ-017 SHALL, with ZERO_REG=1, keep r0 at zero and treat a write to address 0 as a no-op: not committed, wr_count unchanged.
REQ-018 SHALL drive each read port combinationally through a 16:1, N-bit mux tree; read latency is zero cycles from address change.
REQ-019 SHALL drive rd_dataX = 0 whenever rd_addrX=0 and ZERO_REG=1, regardless of stored state or bypass.
REQ-020 SHALL, with BYPASS=1, drive rd_dataX = wr_data when wr_ena=1 and rd_addrX=wr_addr, except under REQ-019.
REQ-021 SHALL, with BYPASS=0, drive rd_dataX from stored contents only; the new value appears the cycle after the write edge.
REQ-022 SHALL support both read ports addressing the same register, and either read port matching wr_addr, in the same cycle, each independently obeying REQ-019..REQ-021.
REQ-023 SHALL increment wr_count by 1 on each committed write and saturate at 255 (no wrap).
REQ-024 SHALL treat X/undriven wr_addr with wr_ena=0 as a no-op; no register changes when wr_ena=0.

Reset
REQ-025 SHALL, while rst=1, immediately (without waiting for clk) force r0..r15 to 0 and wr_count to 0; rd_data0/rd_data1 then reflect zeros, plus bypass data if wr_ena=1 and BYPASS=1.
REQ-026 SHALL ignore writes on any clk edge while rst=1; a write in flight when rst asserts is lost.
REQ-027 SHALL resume normal writes on the first rising clk edge after rst deasserts.

Verification
REQ-028 Reset: pulse rst mid-cycle after writing r5=32'hDEADBEEF -> rd_data0 with rd_addr0=5 reads 0 before the next clk edge; wr_count=0.
REQ-029 Write/read all: write rk = 32'h1000_0000+k for k=1..15, then sweep both read ports -> each returns its value; r0 reads 0; wr_count=15.
REQ-030 Zero register: write 32'hFFFF_FFFF to address 0 with ZERO_REG=1 -> rd_data reads 0 and wr_count is unchanged.
REQ-031 Bypass: wr_ena=1, wr_addr=7, wr_data=32'hA5A5_A5A5, rd_addr0=rd_addr1=7, with old r7=32'h1 -> with BYPASS=1 both ports show A5A5_A5A5 in the same cycle; with BYPASS=0 both show 32'h1 until the edge.
REQ-032 Dual port plus write: rd_addr0=3, rd_addr1=12, write to r9 -> ports 0 and 1 are unaffected; r9 updates; only one register changes.
REQ-033 Saturation: commit 300 writes to r1 -> wr_count holds at 255; r1 holds the last value written.
